bcd4_to_bin: RTL and testbench

//   Sequential converter from four packed BCD digits (A = thousands, B = hundreds,
//   C = tens, D = units) to an unsigned binary value, 0..9999.

---
 rtl/bcd4_to_bin.sv | 138 +++++++++++++
 tb/tb_bcd4_to_bin.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/bcd4_to_bin.sv
// -----------------------------------------------------------------------------
// bcd4_to_bin
//   Sequential converter from four packed BCD digits to an unsigned binary
//   value in the range 0..9999. Horner accumulation (acc = acc*10 + digit)
//   consumes one digit per clock, most significant digit first.
//
//   A start pulse seen in IDLE latches the digits. Four clocks later a
//   one-cycle done pulse marks value/err as valid. If any latched digit is
//   greater than 9, value is forced to 0 and err is set. value and err hold
//   their last results until the next conversion completes.
//
// Ports
//   clk    in   1        system clock, all logic on posedge
//   rst    in   1        synchronous, active-high reset
//   start  in   1        request conversion; sampled only in IDLE
//   A      in   4        thousands digit (BCD)
//   B      in   4        hundreds digit (BCD)
//   C      in   4        tens digit (BCD)
//   D      in   4        units digit (BCD)
//   value  out  VALUE_W  binary result; holds until next completed conversion
//   busy   out  1        high while a conversion is in progress
//   done   out  1        one-cycle pulse: value/err valid
//   err    out  1        set with done if any latched digit > 9
//
// Parameters
//   VALUE_W  width of value; must be >= 14 because 9999 needs 14 bits
// -----------------------------------------------------------------------------
module bcd4_to_bin #(
  parameter int VALUE_W = 14
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [3:0]         A,
  input  logic [3:0]         B,
  input  logic [3:0]         C,
  input  logic [3:0]         D,
  output logic [VALUE_W-1:0] value,
  output logic               busy,
  output logic               done,
  output logic               err
);

  typedef enum logic {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_t;

  state_t state;
  state_t state_next;

  // Latched digits, index 0 = thousands ... index 3 = units.
  logic [3:0]         dig [4];
  logic [1:0]         idx;
  logic [VALUE_W-1:0] acc;
  logic               err_pending;

  logic               accept;
  logic               last_step;
  logic [VALUE_W-1:0] acc_step;
  logic               any_invalid;

  assign accept      = (state == IDLE) && start;
  assign last_step   = (state == CONV) && (idx == 2'd3);
  assign any_invalid = (A > 4'd9) || (B > 4'd9) || (C > 4'd9) || (D > 4'd9);

  // acc*10 built from two shifts so no multiplier is inferred. An invalid
  // digit may wrap this sum; that result is discarded at the final step.
  assign acc_step = (acc << 3) + (acc << 1) + {{(VALUE_W-4){1'b0}}, dig[idx]};

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: the default assignment at the top keeps every path driven, which
  // prevents a latch from being inferred.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (start) state_next = CONV;
      CONV: if (idx == 2'd3) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath and outputs
  // ---------------------------------------------------------------------------
  // The digit latches are only four small registers, so they are cleared on
  // reset along with everything else.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) dig[i] <= '0;
      idx         <= '0;
      acc         <= '0;
      err_pending <= 1'b0;
      value       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      // done only rises on the final step; it drops on every other edge.
      done <= last_step;

      if (accept) begin
        dig[0]      <= A;
        dig[1]      <= B;
        dig[2]      <= C;
        dig[3]      <= D;
        err_pending <= any_invalid;
        acc         <= '0;
        idx         <= '0;
        busy        <= 1'b1;
      end else if (state == CONV) begin
        acc <= acc_step;
        idx <= idx + 2'd1;
        if (last_step) begin
          value <= err_pending ? '0 : acc_step;
          err   <= err_pending;
          busy  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_bcd4_to_bin.sv
// -----------------------------------------------------------------------------
// tb_bcd4_to_bin
//   Self-checking bench for bcd4_to_bin. Inputs are driven and outputs sampled
//   on the falling edge, half a period away from the active rising edge.
// -----------------------------------------------------------------------------
module tb_bcd4_to_bin;

  localparam int VALUE_W = 14;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic [3:0]         a, b, c, d;
  logic [VALUE_W-1:0] value;
  logic               busy;
  logic               done;
  logic               err;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  bcd4_to_bin #(.VALUE_W(VALUE_W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (a),
    .B     (b),
    .C     (c),
    .D     (d),
    .value (value),
    .busy  (busy),
    .done  (done),
    .err   (err)
  );

  typedef struct {
    logic [3:0]  a, b, c, d;
    int unsigned exp_value;
    logic        exp_err;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input int unsigned act,
                       input int unsigned exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One complete conversion: start for one cycle, then scramble the inputs so
  // only latched digits can produce the right answer. Checks busy for four
  // cycles, the done pulse with value/err, and that done drops afterwards.
  task automatic run_conv(input logic [3:0] da, input logic [3:0] db,
                          input logic [3:0] dc, input logic [3:0] dd,
                          input int unsigned exp_v, input logic exp_e,
                          input string name);
    @(negedge clk);
    a = da; b = db; c = dc; d = dd;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = 4'd7; b = 4'd7; c = 4'd7; d = 4'd7;
    for (int i = 0; i < 4; i++) begin
      check({name, " busy"}, busy, 1);
      check({name, " no-done"}, done, 0);
      @(negedge clk);
    end
    check({name, " done"}, done, 1);
    check({name, " busy-low"}, busy, 0);
    check({name, " value"}, value, exp_v);
    check({name, " err"}, err, exp_e);
    @(negedge clk);
    check({name, " done-pulse"}, done, 0);
    check({name, " value-hold"}, value, exp_v);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Directed vectors with hand-computed results. Order matters: an invalid
    // vector is followed by a valid one to show err clears.
    vecs[0] = '{4'd1, 4'd2, 4'd3, 4'd4, 1234, 1'b0};
    vecs[1] = '{4'd9, 4'd9, 4'd9, 4'd9, 9999, 1'b0};
    vecs[2] = '{4'd0, 4'd0, 4'd0, 4'd0, 0,    1'b0};
    vecs[3] = '{4'd0, 4'hA, 4'd0, 4'd0, 0,    1'b1};
    vecs[4] = '{4'd0, 4'd0, 4'd0, 4'd9, 9,    1'b0};
    vecs[5] = '{4'hF, 4'hF, 4'hF, 4'hF, 0,    1'b1};
    vecs[6] = '{4'd9, 4'd0, 4'd0, 4'd0, 9000, 1'b0};
    vecs[7] = '{4'd3, 4'd0, 4'd0, 4'd7, 3007, 1'b0};
    vecs[8] = '{4'd1, 4'd2, 4'd3, 4'hC, 0,    1'b1};
    vecs[9] = '{4'd0, 4'd5, 4'd1, 4'd0, 510,  1'b0};

    rst = 1'b1; start = 1'b0;
    a = 4'd0; b = 4'd0; c = 4'd0; d = 4'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset value", value, 0);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset err", err, 0);

    // Idle with start low must stay idle.
    repeat (3) @(negedge clk);
    check("idle busy", busy, 0);
    check("idle done", done, 0);

    for (int v = 0; v < 10; v++) begin
      run_conv(vecs[v].a, vecs[v].b, vecs[v].c, vecs[v].d,
               vecs[v].exp_value, vecs[v].exp_err, $sformatf("vec%0d", v));
    end

    // start held high: 42 then 1000, done every 5 cycles, start during busy
    // ignored.
    @(negedge clk);
    a = 4'd0; b = 4'd0; c = 4'd4; d = 4'd2;
    start = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (n == 1) begin
        a = 4'd1; b = 4'd0; c = 4'd0; d = 4'd0;
      end
      check($sformatf("b2b done n=%0d", n), done, (n == 5 || n == 10) ? 1 : 0);
      check($sformatf("b2b busy n=%0d", n), busy, (n == 5 || n == 10) ? 0 : 1);
      if (n >= 5 && n <= 9) check($sformatf("b2b value n=%0d", n), value, 42);
      if (n == 10) check("b2b value 1000", value, 1000);
    end
    start = 1'b0;
    @(negedge clk);
    check("b2b done-drop", done, 0);
    check("b2b idle", busy, 0);

    // Reset two cycles into a conversion of 5678 aborts it.
    @(negedge clk);
    a = 4'd5; b = 4'd6; c = 4'd7; d = 4'd8;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("abort busy-before", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort busy", busy, 0);
    check("abort done", done, 0);
    check("abort value", value, 0);
    check("abort err", err, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("abort no-done", done, 0);
      check("abort value-hold", value, 0);
    end
    run_conv(4'd5, 4'd6, 4'd7, 4'd8, 5678, 1'b0, "after-abort");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
